display_scan_mux: RTL and testbench
===================================

// Module: display_scan_mux
// PURPOSE
//  Time-multiplexes a DIGITS-wide packed BCD value onto one shared 4-bit digit bus feeding the
//  seven-segment decoder, and drives one-hot digit enables for the common-anode/cathode drivers.
//  Provides a load handshake: new values are buffered and committed only at a frame boundary,
//  so one scan frame never shows a mix of old and new digits.
// PARAMETERS
//  DIGITS   4      number of multiplexed digits, >= 1
//  SCAN_DIV 50000  clock cycles each digit stays enabled, >= 1
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          synchronous, active-high reset
//  load        in   1          1-cycle strobe: capture value into pending buffer
//  value       in   4*DIGITS   packed BCD, digit i = value[4i+3:4i], digit 0 = least significant
//  data        out  4          digit code to decoder; 4'hF = blank (decoder outputs all-off for 10..15)
//  digit_en    out  DIGITS     one-hot, active-high enable of the digit currently shown
//  frame_start out  1          1-cycle pulse when the scan wraps back to digit 0
//  pending     out  1          high while a loaded value awaits commit
// BEHAVIOUR
//  - All outputs registered; all state updates on rising clk edge only.
//  - Reset (sync, dominates load): prescaler=0, idx=0, disp=0, pend_val=0, pending=0,
//    data=4'h0, digit_en=1 (digit 0), frame_start=0. Reset mid-frame discards pending value.
//  - Prescaler counts 0..SCAN_DIV-1; tick = (prescaler==SCAN_DIV-1); wraps to 0 on tick.
//    SCAN_DIV=1: tick every cycle.
//  - On tick: next = (idx==DIGITS-1) ? 0 : idx+1; idx<=next; digit_en<=1<<next;
//    data<=code(next); frame_start<=(next==0), else frame_start<=0.
//    DIGITS=1: idx stays 0, every tick is a frame boundary.
//  - Each digit enabled exactly SCAN_DIV cycles; full frame = DIGITS*SCAN_DIV cycles.
//  - load: pend_val<=value, pending<=1. Load while pending: latest value overwrites (no queue).
//  - Commit: on tick with next==0: if load same cycle, disp<=value (bypass); else if pending,
//    disp<=pend_val; pending<=0 in both cases. data for digit 0 uses the committed value
//    in that same cycle (no one-frame lag).
//  - Load in a non-boundary cycle: visible from next frame start; latency <= DIGITS*SCAN_DIV.
//  - code(i) = disp digit i; values 10..15 pass through unmodified (decoder blanks them).
//  - No arithmetic on digit values; idx width = clog2(DIGITS) (min 1); prescaler width = clog2(SCAN_DIV) (min 1).
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: code(i) = 4'hF when i>0 and every disp digit j>=i is 0;
//    digit 0 never blanked (value 0 shows "0"). Evaluated on committed disp, not pend_val.
//  Not defined: all digits shown as stored, leading zeros displayed.
// TESTING (DIGITS=4, SCAN_DIV=4 unless noted)
//  1 reset held 3 cycles -> data=0, digit_en=4'b0001, frame_start=0, pending=0; stays 4 cycles after release.
//  2 load value=16'h1234 at cycle 2 after reset -> pending=1 until boundary at cycle 16; then
//    digit_en cycles 0001,0010,0100,1000 each 4 cycles with data 4,3,2,1; frame_start 1 cycle at each wrap.
//  3 load 16'h1111 then 16'h5678 mid-frame -> next frame shows 8,7,6,5 only; 1111 never displayed.
//  4 load 16'h9090 in the exact boundary-tick cycle -> digit 0 shows 0 from that edge, pending stays 0.
//  5 pending=1, reset asserted mid-frame -> disp=0, pending=0; display reads 0 after reset.
//  6 LEADING_ZERO_BLANK_EN, value 16'h0042 -> data 2,4,F,F; value 16'h0000 -> 0,F,F,F; without macro 2,4,0,0.

Source files
------------

// File: rtl/display_scan_mux_if.sv
// display_scan_mux_if: load handshake and scan outputs of the display scan multiplexer
interface display_scan_mux_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [3:0]            data;
  logic [DIGITS-1:0]     digit_en;
  logic                  frame_start;
  logic                  pending;
  modport master (output load, value, input data, digit_en, frame_start, pending);
  modport slave  (input load, value, output data, digit_en, frame_start, pending);
endinterface

// File: rtl/display_scan_mux.sv
// display_scan_mux: frame-synchronous BCD scan multiplexer; LEADING_ZERO_BLANK_EN blanks leading zeros
module display_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               reset,
  display_scan_mux_if.slave  bus
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx, nxt;
  logic [VW-1:0] disp, disp_n, pend_val;
  logic          tick, wrap;
  logic [3:0]    code;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] zero_up;
  logic              zrun;
`endif
  always_comb begin
    tick   = presc == PW'(SCAN_DIV - 1);
    nxt    = idx == IW'(DIGITS - 1) ? '0 : IW'(idx + 1'b1);
    wrap   = tick && nxt == '0;
    // a load landing on the boundary edge bypasses the pending buffer
    disp_n = !wrap ? disp : bus.load ? bus.value : bus.pending ? pend_val : disp;
`ifdef LEADING_ZERO_BLANK_EN
    zero_up = '0;
    zrun    = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zrun       = zrun && disp_n[4*i +: 4] == 4'h0;
      zero_up[i] = zrun;
    end
    code = (nxt != '0 && zero_up[nxt]) ? 4'hF : disp_n[4*nxt +: 4];
`else
    code = disp_n[4*nxt +: 4];
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      presc           <= '0;
      idx             <= '0;
      disp            <= '0;
      pend_val        <= '0;
      bus.pending     <= 1'b0;
      bus.data        <= 4'h0;
      bus.digit_en    <= DIGITS'(1);
      bus.frame_start <= 1'b0;
    end else begin
      presc           <= tick ? '0 : PW'(presc + 1'b1);
      disp            <= disp_n;
      bus.frame_start <= wrap;
      bus.pending     <= wrap ? 1'b0 : bus.load | bus.pending;
      if (bus.load) pend_val <= bus.value;
      if (tick) begin
        idx          <= nxt;
        bus.digit_en <= DIGITS'(1) << nxt;
        bus.data     <= code;
      end
    end
  end
endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: scoreboard bench with a frame-arithmetic reference model
module tb_display_scan_mux;
  localparam int D = 4;
  localparam int S = 4;
  localparam int F = D * S;
  typedef struct packed {
    logic [3:0]   data;
    logic [D-1:0] en;
    logic         fs;
    logic         pnd;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  display_scan_mux_if #(.DIGITS(D)) bus ();
  display_scan_mux #(.DIGITS(D), .SCAN_DIV(S)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  int n = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  bit m_pnd = 1'b0;
  function automatic logic [3:0] digit_of(input logic [15:0] v, input int i);
    logic [3:0] d;
    d = 4'((v >> (4 * i)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && (v >> (4 * i)) == 16'h0) d = 4'hF;
`endif
    return d;
  endfunction
  task automatic model(input logic r, input logic l, input logic [15:0] v);
    exp_t e;
    int k;
    if (r) begin
      n = 0; m_disp = '0; m_pend = '0; m_pnd = 1'b0;
    end else begin
      n++;
      if (n % F == 0) begin
        m_disp = l ? v : (m_pnd ? m_pend : m_disp);
        m_pnd  = 1'b0;
      end else if (l) begin
        m_pend = v;
        m_pnd  = 1'b1;
      end
    end
    k      = (n / S) % D;
    e.data = digit_of(m_disp, k);
    e.en   = D'(1 << k);
    e.fs   = !r && n > 0 && n % F == 0;
    e.pnd  = m_pnd;
    q.push_back(e);
  endtask
  task automatic step(input logic r, input logic l, input logic [15:0] v);
    @(negedge clk);
    reset = r; bus.load = l; bus.value = v;
    model(r, l, v);
    started = 1'b1;
  endtask
  task automatic idle(input int c);
    for (int i = 0; i < c; i++) step(1'b0, 1'b0, 16'h0);
  endtask
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    end
  endfunction
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (started) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty t=%0t got 0 entries expected 1", $time);
      end else begin
        e = q.pop_front();
        chk("data", 32'(bus.data), 32'(e.data));
        chk("digit_en", 32'(bus.digit_en), 32'(e.en));
        chk("frame_start", 32'(bus.frame_start), 32'(e.fs));
        chk("pending", 32'(bus.pending), 32'(e.pnd));
      end
    end
  end
  initial begin
    reset = 1'b1; bus.load = 1'b0; bus.value = '0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0);
    idle(4);
    step(1'b1, 1'b0, 16'h0);
    idle(1);
    step(1'b0, 1'b1, 16'h1234);
    idle(2 * F);
    step(1'b0, 1'b1, 16'h1111);
    idle(3);
    step(1'b0, 1'b1, 16'h5678);
    idle(2 * F);
    while ((n + 1) % F != 0) idle(1);
    step(1'b0, 1'b1, 16'h9090);
    idle(F + 2);
    step(1'b0, 1'b1, 16'h4321);
    idle(5);
    step(1'b1, 1'b0, 16'h0);
    idle(F + 3);
    step(1'b0, 1'b1, 16'h0042);
    idle(2 * F);
    step(1'b0, 1'b1, 16'h0000);
    idle(2 * F);
    step(1'b0, 1'b1, 16'h0F0A);
    idle(2 * F);
    for (int i = 0; i < 800; i++)
      step(($urandom_range(99) == 0), ($urandom_range(7) == 0), 16'($urandom));
    idle(2);
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
